// File: rtl/freqdiv_prog.sv
// freqdiv_prog: NUM_CH independent programmable clock dividers with shadowed
// divisors applied at period boundaries and a shared phase-realign sync.
module freqdiv_prog #(
    parameter int NUM_CH    = 4,
    parameter int WIDTH     = 16,
    parameter int DIV_RESET = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       en,
    input  logic [NUM_CH-1:0]       div_wr,
    input  logic [NUM_CH*WIDTH-1:0] div_in,
    input  logic                    sync,
    output logic [NUM_CH-1:0]       clk_div,
    output logic [NUM_CH-1:0]       tick,
    output logic [NUM_CH*WIDTH-1:0] div_cur,
    output logic [NUM_CH-1:0]       pending
);
    localparam logic [WIDTH-1:0] D0 = (DIV_RESET < 2) ? WIDTH'(2) : WIDTH'(DIV_RESET);
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [WIDTH-1:0] d, s, cnt, w, nd, cnt_n;
        logic [WIDTH:0]   half;
        logic             p, cd, tk, wrap;
        always_comb begin
            w     = (div_in[c*WIDTH +: WIDTH] < WIDTH'(2)) ? WIDTH'(2) : div_in[c*WIDTH +: WIDTH];
            nd    = div_wr[c] ? w : p ? s : d;
            wrap  = sync || (cnt == d - WIDTH'(1));
            cnt_n = cnt + WIDTH'(1);
            half  = ({1'b0, d} + (WIDTH+1)'(1)) >> 1;
        end
        // a write landing on the wrap edge bypasses the shadow and applies at once
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                d   <= D0;
                s   <= D0;
                cnt <= D0 - WIDTH'(1);
                p   <= 1'b0;
                cd  <= 1'b0;
                tk  <= 1'b0;
            end else if (!en[c]) begin
                d   <= nd;
                s   <= div_wr[c] ? w : s;
                cnt <= nd - WIDTH'(1);
                p   <= 1'b0;
                cd  <= 1'b0;
                tk  <= 1'b0;
            end else if (wrap) begin
                d   <= nd;
                s   <= div_wr[c] ? w : s;
                cnt <= '0;
                p   <= 1'b0;
                cd  <= 1'b1;
                tk  <= 1'b1;
            end else begin
                s   <= div_wr[c] ? w : s;
                cnt <= cnt_n;
                p   <= p | div_wr[c];
                cd  <= {1'b0, cnt_n} < half;
                tk  <= 1'b0;
            end
        end
        assign clk_div[c]                = cd;
        assign tick[c]                   = tk;
        assign pending[c]                = p;
        assign div_cur[c*WIDTH +: WIDTH] = d;
    end
endmodule

// File: tb/tb_freqdiv_prog.sv
// tb_freqdiv_prog: directed table plus hand-written sequences for freqdiv_prog.
module tb_freqdiv_prog;
    localparam int N = 4;
    localparam int W = 16;
    logic clk = 0;
    logic reset = 1;
    logic [N-1:0] en = '0;
    logic [N-1:0] div_wr = '0;
    logic [N*W-1:0] div_in = '0;
    logic sync = 0;
    logic [N-1:0] clk_div, tick, pending;
    logic [N*W-1:0] div_cur;
    int n_chk = 0;
    int n_fail = 0;

    freqdiv_prog #(.NUM_CH(N), .WIDTH(W), .DIV_RESET(2)) dut (
        .clk(clk), .reset(reset), .en(en), .div_wr(div_wr), .div_in(div_in),
        .sync(sync), .clk_div(clk_div), .tick(tick), .div_cur(div_cur), .pending(pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rs;
        logic [3:0]  en, wr;
        logic [15:0] din;
        logic        sy;
        int          ch;
        logic        cd, tk, pd;
        logic [15:0] dc;
    } vec_t;
    vec_t v[$];

    task automatic add(input logic rs, input logic [3:0] e, wr, input logic [15:0] din,
                       input logic sy, input int ch, input logic cd, tk, pd, input logic [15:0] dc);
        vec_t x;
        x = '{rs:rs, en:e, wr:wr, din:din, sy:sy, ch:ch, cd:cd, tk:tk, pd:pd, dc:dc};
        v.push_back(x);
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic logic [W-1:0] dcur(input int c);
        return div_cur[c*W +: W];
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [5:0] p6;
        logic [4:0] p5;
        logic [7:0] p8;
        int t0, nco, first;
        // reset state and defaults, ch1 reprogram to 5
        add(1, 4'h0, 4'h0, 0, 0, 0, 0, 0, 0, 2);
        add(0, 4'hF, 4'h0, 0, 0, 0, 1, 1, 0, 2);
        add(0, 4'hF, 4'h2, 5, 0, 1, 0, 0, 1, 2);
        add(0, 4'hF, 4'h0, 0, 0, 1, 1, 1, 0, 5);
        add(0, 4'hF, 4'h0, 0, 0, 0, 0, 0, 0, 2);
        add(0, 4'hF, 4'h0, 0, 0, 1, 1, 0, 0, 5);
        add(0, 4'hF, 4'h0, 0, 0, 1, 0, 0, 0, 5);
        add(0, 4'hF, 4'h0, 0, 0, 1, 0, 0, 0, 5);
        add(0, 4'hF, 4'h0, 0, 0, 1, 1, 1, 0, 5);
        add(0, 4'hF, 4'h0, 0, 0, 0, 1, 1, 0, 2);
        // ch2: write on wrap edge, last-write-wins, clamp of 0
        add(1, 4'h0, 4'h0, 0, 0, 2, 0, 0, 0, 2);
        add(0, 4'hF, 4'h4, 4, 0, 2, 1, 1, 0, 4);
        add(0, 4'hF, 4'h4, 3, 0, 2, 1, 0, 1, 4);
        add(0, 4'hF, 4'h4, 7, 0, 2, 0, 0, 1, 4);
        add(0, 4'hF, 4'h0, 0, 0, 2, 0, 0, 1, 4);
        add(0, 4'hF, 4'h0, 0, 0, 2, 1, 1, 0, 7);
        p6 = 6'b111000;
        for (int i = 0; i < 6; i++) add(0, 4'hF, 4'h0, 0, 0, 2, p6[5-i], 0, 0, 7);
        add(0, 4'hF, 4'h0, 0, 0, 2, 1, 1, 0, 7);
        add(0, 4'hF, 4'h4, 0, 0, 2, 1, 0, 1, 7);
        p5 = 5'b11000;
        for (int i = 0; i < 5; i++) add(0, 4'hF, 4'h0, 0, 0, 2, p5[4-i], 0, 1, 7);
        add(0, 4'hF, 4'h0, 0, 0, 2, 1, 1, 0, 2);
        add(0, 4'hF, 4'h0, 0, 0, 2, 0, 0, 0, 2);
        // ch3 disabled write, enable, sync ignored while disabled
        add(1, 4'h0, 4'h0, 0, 0, 3, 0, 0, 0, 2);
        add(0, 4'h7, 4'h8, 9, 0, 3, 0, 0, 0, 9);
        add(0, 4'h7, 4'h0, 0, 0, 3, 0, 0, 0, 9);
        add(0, 4'hF, 4'h0, 0, 0, 3, 1, 1, 0, 9);
        p8 = 8'b11110000;
        for (int i = 0; i < 8; i++) add(0, 4'hF, 4'h0, 0, 0, 3, p8[7-i], 0, 0, 9);
        add(0, 4'hF, 4'h0, 0, 0, 3, 1, 1, 0, 9);
        add(0, 4'h7, 4'h0, 0, 1, 3, 0, 0, 0, 9);
        add(0, 4'hF, 4'h0, 0, 0, 3, 1, 1, 0, 9);

        @(negedge clk);
        foreach (v[i]) begin
            en = v[i].en;
            div_wr = v[i].wr;
            div_in = {N{v[i].din}};
            sync = v[i].sy;
            if (v[i].rs) begin
                reset = 1;
                #1;
            end else step();
            chk($sformatf("row%0d clk_div", i), 32'(clk_div[v[i].ch]), 32'(v[i].cd));
            chk($sformatf("row%0d tick", i), 32'(tick[v[i].ch]), 32'(v[i].tk));
            chk($sformatf("row%0d pending", i), 32'(pending[v[i].ch]), 32'(v[i].pd));
            chk($sformatf("row%0d div_cur", i), 32'(dcur(v[i].ch)), 32'(v[i].dc));
            reset = 0;
        end

        // sync alignment of D=4 and D=6, sync held, coincident ticks every 12
        @(negedge clk);
        reset = 1;
        #1;
        reset = 0;
        en = 4'hF;
        sync = 0;
        div_in = '0;
        div_in[0*W +: W] = 16'd4;
        div_in[1*W +: W] = 16'd6;
        div_wr = 4'b0011;
        step();
        div_wr = '0;
        chk("sync div_cur0", 32'(dcur(0)), 32'd4);
        chk("sync div_cur1", 32'(dcur(1)), 32'd6);
        repeat (3) step();
        sync = 1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("sync%0d tick", k), 32'(tick[1:0]), 32'h3);
            chk($sformatf("sync%0d clk_div", k), 32'(clk_div[1:0]), 32'h3);
        end
        sync = 0;
        t0 = 0;
        nco = 0;
        first = 0;
        for (int k = 1; k <= 24; k++) begin
            step();
            if (tick[0]) t0++;
            if (tick[0] && tick[1]) begin
                nco++;
                if (first == 0) first = k;
            end
        end
        chk("coinc first", 32'(first), 32'd12);
        chk("coinc count", 32'(nco), 32'd2);
        chk("ch0 tick count", 32'(t0), 32'd6);

        // async reset mid-period discards a pending write
        reset = 1;
        #1;
        reset = 0;
        en = 4'hF;
        div_in = {N{16'd4}};
        div_wr = 4'b0010;
        step();
        div_in = {N{16'd5}};
        step();
        div_wr = '0;
        chk("pre-rst pending1", 32'(pending[1]), 32'd1);
        chk("pre-rst clk_div1", 32'(clk_div[1]), 32'd1);
        chk("pre-rst div_cur1", 32'(dcur(1)), 32'd4);
        #2;
        reset = 1;
        #1;
        chk("async clk_div", 32'(clk_div), 32'h0);
        chk("async tick", 32'(tick), 32'h0);
        chk("async pending", 32'(pending), 32'h0);
        chk("async div_cur1", 32'(dcur(1)), 32'd2);
        reset = 0;
        step();
        chk("post-rst tick1", 32'(tick[1]), 32'd1);
        chk("post-rst clk_div1", 32'(clk_div[1]), 32'd1);
        step();
        chk("post-rst clk_div1 b", 32'(clk_div[1]), 32'd0);
        chk("post-rst pending1", 32'(pending[1]), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
